// File: rtl/noc_flit_pkg.sv
// Shared flit-format definitions for the NoC assembler/depacketizer pair.
// Flag bit offsets (from the flit MSB), VC field helpers, flit kind decode.
package noc_flit_pkg;

    // Flag bit index within a W-bit flit is W - <offset>.
    localparam int FLAG_VALID_OFS = 1;
    localparam int FLAG_HEAD_OFS  = 2;
    localparam int FLAG_TAIL_OFS  = 3;

    typedef enum logic [1:0] {
        FK_HEAD,
        FK_TAIL,
        FK_BAD
    } flit_kind_e;

    // VC field sits directly below the three flag bits.
    function automatic int vc_msb(input int w);
        return w - FLAG_TAIL_OFS - 1;
    endfunction

    function automatic int vc_lsb(input int w, input int vcw);
        return w - FLAG_TAIL_OFS - vcw;
    endfunction

    // Head-only and tail-only are the legal kinds; both or neither is BAD.
    function automatic flit_kind_e flit_kind(input logic head,
                                             input logic tail);
        unique case ({head, tail})
            2'b10:   return FK_HEAD;
            2'b01:   return FK_TAIL;
            default: return FK_BAD;
        endcase
    endfunction

endpackage

// File: rtl/flit_assembler_2.sv
// Assembles a head/tail flit pair into one registered 2-flit packet word,
// dropping malformed sequences and backpressuring the router.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   flit_in     flit from router {valid, head, tail, vc, dest, data}
//   ready_out   flit accepted when high and flit_in valid is set
//   pkt_out     {head_flit, tail_flit}, zero when no packet is held
//   ready_in    downstream accept
//   err_count   saturating malformed-event count
//
// Build option: define FLIT_ASSEMBLER_ERR_CNT_EN to implement the error
// counter; without it err_count is tied to zero (drop behaviour unchanged).
module flit_assembler_2
    import noc_flit_pkg::*;
#(
    parameter int WIDTH_PKT        = 36,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int ERR_CNT_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH_PKT/2-1:0]   flit_in,
    output logic                     ready_out,
    output logic [WIDTH_PKT-1:0]     pkt_out,
    input  logic                     ready_in,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int W      = WIDTH_PKT / 2;
    localparam int V_BIT  = W - FLAG_VALID_OFS;
    localparam int H_BIT  = W - FLAG_HEAD_OFS;
    localparam int T_BIT  = W - FLAG_TAIL_OFS;
    localparam int VC_HI  = vc_msb(W);
    localparam int VC_LO  = vc_lsb(W, VC_ADDRESS_WIDTH);
    localparam int DATA_W = VC_LO - ADDRESS_WIDTH;

    // Flags, VC and dest must leave room for at least one data bit.
    if (DATA_W < 1) begin : g_layout_too_narrow
    end

    logic [W-1:0]         hreg_q, hreg_d;
    logic                 h_v_q, h_v_d;
    logic [WIDTH_PKT-1:0] oreg_q, oreg_d;
    logic                 o_v_q, o_v_d;
    logic                 accept;
    logic                 vc_match;
    logic                 err_inc;
    flit_kind_e           kind;

    // Only a full head register facing a stalled output blocks the router.
    assign ready_out = !(h_v_q && o_v_q && !ready_in);
    assign accept    = ready_out && flit_in[V_BIT];
    assign kind      = flit_kind(flit_in[H_BIT], flit_in[T_BIT]);
    assign vc_match  = (hreg_q[VC_HI:VC_LO] == flit_in[VC_HI:VC_LO]);
    assign pkt_out   = o_v_q ? oreg_q : '0;

    always_comb begin
        hreg_d  = hreg_q;
        h_v_d   = h_v_q;
        oreg_d  = oreg_q;
        o_v_d   = o_v_q;
        err_inc = 1'b0;

        if (o_v_q && ready_in) begin
            o_v_d = 1'b0;
        end

        // A tail load can only coincide with o_v_q when ready_in drains
        // it, since ready_out is low otherwise.
        if (accept) begin
            unique case (kind)
                FK_HEAD: begin
                    hreg_d  = flit_in;
                    h_v_d   = 1'b1;
                    err_inc = h_v_q;
                end
                FK_TAIL: begin
                    if (!h_v_q) begin
                        err_inc = 1'b1;
                    end else if (vc_match) begin
                        oreg_d = {hreg_q, flit_in};
                        o_v_d  = 1'b1;
                        h_v_d  = 1'b0;
                    end else begin
                        h_v_d   = 1'b0;
                        err_inc = 1'b1;
                    end
                end
                default: begin
                    err_inc = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hreg_q <= '0;
            h_v_q  <= 1'b0;
            oreg_q <= '0;
            o_v_q  <= 1'b0;
        end else begin
            hreg_q <= hreg_d;
            h_v_q  <= h_v_d;
            oreg_q <= oreg_d;
            o_v_q  <= o_v_d;
        end
    end

`ifdef FLIT_ASSEMBLER_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (err_inc && !(&err_q)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_flit_assembler_2.sv
// Self-checking bench for flit_assembler_2: directed scenarios plus a
// randomized phase, checked against a queue-based packet model.
module tb_flit_assembler_2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] flit_in = '0;
    logic        ready_out;
    logic [35:0] pkt_out;
    logic        ready_in = 1'b0;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    // Reference model: pending head plus a queue of packets awaiting drain.
    logic        m_hv;
    logic [17:0] m_h;
    logic [35:0] m_q[$];
    int          m_err;
    int          dut_pkts;

    flit_assembler_2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flit_in   (flit_in),
        .ready_out (ready_out),
        .pkt_out   (pkt_out),
        .ready_in  (ready_in),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] mk(input logic h, input logic t,
                                       input logic vc, input logic [3:0] d,
                                       input logic [9:0] data);
        return {1'b1, h, t, vc, d, data};
    endfunction

    function automatic int exp_err(input int n);
`ifdef FLIT_ASSEMBLER_ERR_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs,
                       input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bump();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_clear();
        m_hv = 1'b0;
        m_h = '0;
        m_q.delete();
        m_err = 0;
        dut_pkts = 0;
    endtask

    // One cycle: drive at negedge, check, advance model, land after posedge.
    task automatic step(input logic [17:0] f, input logic ri);
        logic exp_rdy;
        logic acc;
        @(negedge clk);
        flit_in = f;
        ready_in = ri;
        #1;
        exp_rdy = !(m_hv && m_q.size() != 0 && !ri);
        chk("ready_out", ready_out, exp_rdy);
        chk("pkt_out", pkt_out, m_q.size() != 0 ? m_q[0] : 36'd0);
        chk("err_count", err_count, exp_err(m_err));
        if (pkt_out[35] && ri) dut_pkts++;
        acc = exp_rdy && f[17];
        if (m_q.size() != 0 && ri) void'(m_q.pop_front());
        if (acc) begin
            if (f[16] && !f[15]) begin
                if (m_hv) bump();
                m_hv = 1'b1;
                m_h = f;
            end else if (!f[16] && f[15]) begin
                if (!m_hv) bump();
                else if (f[14] != m_h[14]) bump();
                else m_q.push_back({m_h, f});
                m_hv = 1'b0;
            end else begin
                bump();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flit_in = '0;
        ready_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    logic [17:0] ha, ta, hb, tb2, hx;

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_pkt", pkt_out, 36'd0);
        chk("rst_err", err_count, 36'd0);
        chk("rst_ready", ready_out, 36'd1);

        // 1: basic packet
        ha = mk(1, 0, 0, 4'd3, 10'h005);
        ta = mk(0, 1, 0, 4'd2, 10'h234);
        step(ha, 1);
        step(ta, 1);
        chk("t1_pkt", pkt_out, {ha, ta});
        chk("t1_err", err_count, 36'd0);
        step('0, 1);
        chk("t1_drain", pkt_out, 36'd0);

        // 2: backpressure, two packets in order
        do_reset();
        hb = mk(1, 0, 1, 4'd9, 10'h3A5);
        tb2 = mk(0, 1, 1, 4'd1, 10'h15A);
        step(ha, 0);
        step(ta, 0);
        step(hb, 0);
        chk("t2_ready_low", ready_out, 36'd0);
        for (int i = 0; i < 4; i++) begin
            step(tb2, 0);
            chk("t2_stable", pkt_out, {ha, ta});
        end
        step(tb2, 1);
        chk("t2_second", pkt_out, {hb, tb2});
        step('0, 1);
        chk("t2_pkts", dut_pkts, 36'd2);

        // 3: orphan tail, then head+tail flagged flit
        do_reset();
        step(ta, 1);
        step(mk(1, 1, 0, 4'd0, 10'h0), 1);
        step('0, 1);
        chk("t3_err", err_count, exp_err(2));
        chk("t3_pkt", pkt_out, 36'd0);

        // 4: orphan head replaced by second head
        do_reset();
        hx = mk(1, 0, 1, 4'd5, 10'h077);
        step(ha, 1);
        step(hx, 1);
        step(tb2, 1);
        chk("t4_pkt", pkt_out, {hx, tb2});
        chk("t4_err", err_count, exp_err(1));
        step('0, 1);
        chk("t4_pkts", dut_pkts, 36'd1);

        // 5: VC mismatch, then saturation
        do_reset();
        step(ha, 1);
        step(tb2, 1);
        step('0, 1);
        chk("t5_err", err_count, exp_err(1));
        chk("t5_nopkt", dut_pkts, 36'd0);
        for (int i = 0; i < 300; i++) step(mk(0, 0, 0, 4'd0, 10'(i)), 1);
        chk("t5_sat", err_count, exp_err(255));

        // 6: reset mid-packet discards the head
        do_reset();
        step(ha, 1);
        do_reset();
        chk("t6_rst_ready", ready_out, 36'd1);
        step(ta, 1);
        step('0, 1);
        chk("t6_err", err_count, exp_err(1));
        chk("t6_nopkt", dut_pkts, 36'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [17:0] f;
            int k;
            k = $urandom_range(0, 9);
            f = mk(k < 4, (k >= 4 && k < 8) || k == 8, $urandom_range(0, 1),
                   4'($urandom), 10'($urandom));
            if ($urandom_range(0, 9) == 0) f[17] = 1'b0;
            step(f, $urandom_range(0, 9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
